// File: rtl/prog_loader_if.sv
// Host byte stream, memory port-B write bus and CPU boot status of the program loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [15:0]       mem_data_b;
  logic              mem_w_en_b;
  logic              cpu_reset;
  logic              done;
  logic              error;

  // master = loader, slave = host link / memory / CPU side
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr_b, mem_data_b, mem_w_en_b, cpu_reset, done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr_b, mem_data_b, mem_w_en_b, cpu_reset, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/data/CHK frames, writes 16-bit words through port B
// and releases cpu_reset only once the image checksum matches.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.master bus
);
  localparam int unsigned LEN_W = 16;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(2 ** ADDR_W);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t           state;
  logic [7:0]       len_hi;
  logic [7:0]       hi_byte;
  logic [7:0]       chk;
  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic [LEN_W-1:0] len_c;

  assign accept = bus.rx_valid & bus.rx_ready;
  assign len_c  = {len_hi, bus.rx_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      len_hi         <= '0;
      hi_byte        <= '0;
      chk            <= '0;
      remaining      <= '0;
      bus.rx_ready   <= 1'b1;
      bus.mem_addr_b <= ADDR_W'(BASE_ADDR);
      bus.mem_data_b <= '0;
      bus.mem_w_en_b <= 1'b0;
      bus.cpu_reset  <= 1'b1;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      bus.mem_w_en_b <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && bus.rx_data == SYNC_BYTE) begin
            chk            <= '0;
            bus.mem_addr_b <= ADDR_W'(BASE_ADDR);
            state          <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi <= bus.rx_data;
            chk    <= chk ^ bus.rx_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            chk       <= chk ^ bus.rx_data;
            remaining <= len_c;
            if (len_c == '0) begin
              state <= CHECK;
            end else if ({1'b0, len_c} > MAX_LEN) begin
              bus.error <= 1'b1;
              state     <= ERROR;
            end else begin
              state <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_byte <= bus.rx_data;
            chk     <= chk ^ bus.rx_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          // Stall the link for the single write cycle that follows
          if (accept) begin
            chk            <= chk ^ bus.rx_data;
            bus.mem_data_b <= {hi_byte, bus.rx_data};
            bus.mem_w_en_b <= 1'b1;
            bus.rx_ready   <= 1'b0;
            state          <= WRITE;
          end
        end
        WRITE: begin
          bus.mem_addr_b <= bus.mem_addr_b + ADDR_W'(1);
          remaining      <= remaining - LEN_W'(1);
          bus.rx_ready   <= 1'b1;
          state          <= (remaining == LEN_W'(1)) ? CHECK : DATA_HI;
        end
        CHECK: begin
          if (accept) begin
            if (bus.rx_data == chk) begin
              bus.done      <= 1'b1;
              bus.cpu_reset <= 1'b0;
              state         <= DONE;
            end else begin
              bus.error <= 1'b1;
              state     <= ERROR;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        ERROR: begin
          // Only a fresh SYNC recovers; the CPU stays held meanwhile
          if (accept && bus.rx_data == SYNC_BYTE) begin
            bus.error      <= 1'b0;
            chk            <= '0;
            bus.mem_addr_b <= ADDR_W'(BASE_ADDR);
            state          <= LEN_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/empty/bad-checksum/oversize frames, stalls and mid-frame reset.
module tb_prog_loader;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   wen_wide = 0;
  int   ready_bad = 0;
  logic prev_wen = 1'b0;
  logic [25:0] wq[$];

  prog_loader_if #(.ADDR_W(10)) bus();

  prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Write monitor: one sample per clock on the falling edge
  always @(negedge clk) begin
    if (bus.mem_w_en_b) begin
      wq.push_back({bus.mem_addr_b, bus.mem_data_b});
      if (prev_wen) wen_wide++;
      if (bus.rx_ready) ready_bad++;
    end
    prev_wen <= bus.mem_w_en_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rx_ready_timeout", 32'(n), 32'(0));
    @(negedge clk);
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(1));
    chk({tag, "_addr"},     32'(bus.mem_addr_b), 32'(0));
    chk({tag, "_data"},     32'(bus.mem_data_b), 32'(0));
    chk({tag, "_wen"},      32'(bus.mem_w_en_b), 32'(0));
    chk({tag, "_cpu_reset"},32'(bus.cpu_reset), 32'(1));
    chk({tag, "_done"},     32'(bus.done), 32'(0));
    chk({tag, "_error"},    32'(bus.error), 32'(0));
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    reset = 1'b0;
    idle(1);

    // Good two-word frame, rx_valid held high throughout; CHK = 0x42
    send_seq('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    chk("f1_wen_latency", 32'(bus.mem_w_en_b), 32'(1));
    chk("f1_stall", 32'(bus.rx_ready), 32'(0));
    chk("f1_cpu_held", 32'(bus.cpu_reset), 32'(1));
    send(8'h42);
    chk("f1_done", 32'(bus.done), 32'(1));
    chk("f1_cpu_run", 32'(bus.cpu_reset), 32'(0));
    idle(2);
    chk("f1_nwrites", 32'(wq.size()), 32'(2));
    chk("f1_w0", 32'(wq[0]), {6'd0, 10'd0, 16'h1234});
    chk("f1_w1", 32'(wq[1]), {6'd0, 10'd1, 16'hABCD});
    send(8'hA5);
    chk("f1_done_sticky", 32'(bus.done), 32'(1));

    // Empty image
    do_reset(); reset = 1'b0; wq.delete();
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
    idle(2);
    chk("f2_done", 32'(bus.done), 32'(1));
    chk("f2_nwrites", 32'(wq.size()), 32'(0));

    // Bad checksum (good would be 0x72), then recovery by resend
    do_reset(); reset = 1'b0; wq.delete();
    send_seq('{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hFF});
    idle(1);
    chk("f3_error", 32'(bus.error), 32'(1));
    chk("f3_cpu_held", 32'(bus.cpu_reset), 32'(1));
    chk("f3_done", 32'(bus.done), 32'(0));
    chk("f3_w0", 32'(wq[0]), {6'd0, 10'd0, 16'hDEAD});
    send(8'hA5);
    chk("f3_err_clear", 32'(bus.error), 32'(0));
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    idle(1);
    chk("f3_redo_done", 32'(bus.done), 32'(1));
    chk("f3_redo_err", 32'(bus.error), 32'(0));
    chk("f3_nwrites", 32'(wq.size()), 32'(3));

    // Oversize length 0x401, then the 0x400 boundary that must be accepted
    do_reset(); reset = 1'b0; wq.delete();
    send_seq('{8'hA5, 8'h04, 8'h01});
    chk("f4_error", 32'(bus.error), 32'(1));
    idle(3);
    chk("f4_nwrites", 32'(wq.size()), 32'(0));
    do_reset(); reset = 1'b0;
    send_seq('{8'hA5, 8'h04, 8'h00});
    chk("f4_max_ok", 32'(bus.error), 32'(0));

    // SYNC value inside the payload is data; CHK = 01^A5^A5 = 0x01
    do_reset(); reset = 1'b0; wq.delete();
    send_seq('{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01});
    idle(1);
    chk("f5_done", 32'(bus.done), 32'(1));
    chk("f5_w0", 32'(wq[0]), {6'd0, 10'd0, 16'hA5A5});

    // Reset after the first of three words, then a fresh frame; CHK = 0x50
    do_reset(); reset = 1'b0; wq.delete();
    send_seq('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22});
    idle(1);
    do_reset();
    check_reset_vals("f6_rst");
    reset = 1'b0;
    send_seq('{8'h33, 8'h44, 8'h55, 8'h66});
    idle(2);
    chk("f6_nwrites_abort", 32'(wq.size()), 32'(1));
    chk("f6_no_done", 32'(bus.done), 32'(0));
    send_seq('{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50});
    idle(1);
    chk("f6_done", 32'(bus.done), 32'(1));
    chk("f6_nwrites", 32'(wq.size()), 32'(2));
    chk("f6_w1", 32'(wq[1]), {6'd0, 10'd0, 16'hBEEF});

    chk("wen_one_cycle", 32'(wen_wide), 32'(0));
    chk("ready_low_on_write", 32'(ready_bad), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
